// File: rtl/match_logger_pkg.sv
// Shared constants and types for the match event logger.
// Provides the default timestamp, FIFO depth and counter widths plus the
// event word type carried from the logger to its consumer.
package match_logger_pkg;

  localparam int DEF_TS_WIDTH  = 16;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_CNT_WIDTH = 8;

  // One stored event: the timestamp at which a match was accepted.
  typedef logic [DEF_TS_WIDTH-1:0] event_word_t;

endpackage

// File: rtl/match_event_logger_if.sv
// Event delivery channel from the logger to its consumer.
// Signals: event_valid (head holds an event), event_ready (consumer takes
// the head), event_timestamp (timestamp of the head event).
// master = logger side, slave = consumer side.
interface match_event_logger_if #(
  parameter int TS_WIDTH = match_logger_pkg::DEF_TS_WIDTH
);

  logic                event_valid;
  logic                event_ready;
  logic [TS_WIDTH-1:0] event_timestamp;

  modport master (
    output event_valid,
    output event_timestamp,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_timestamp,
    output event_ready
  );

endinterface

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Ports: clock, reset (sync active-high), push/din (write), pop (read
// request, ignored while empty), dout (head word), level (entries stored),
// full, empty. A push while full is accepted only when a pop happens on the
// same edge; otherwise it is discarded and storage is left untouched.
module event_fifo
  import match_logger_pkg::*;
#(
  parameter int WIDTH = DEF_TS_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Accept/reject decisions; a full FIFO still takes a push when it pops too.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (level_r != {LW{1'b0}}) begin
      pop_ok_s = pop;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (level_r != LW'(DEPTH)) begin
      push_ok_s = push;
    end else begin
      push_ok_s = push & pop_ok_s;
    end
  end

  // Storage write; contents are deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (push_ok_s && !reset) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = (level_r == LW'(DEPTH));
  assign empty = (level_r == {LW{1'b0}});

endmodule

// File: rtl/match_event_logger.sv
// Timestamps match pulses from a 1011 sequence detector and queues them.
// Ports: clock, reset (sync active-high), detector_in (match pulse),
// enable (advance timestamp / accept matches), clear_overflow,
// event_count (saturating total of matches, dropped ones included),
// overflow (sticky drop flag), fifo_level (stored entries), and bus
// (event_valid / event_ready / event_timestamp channel to the consumer).
module match_event_logger
  import match_logger_pkg::*;
#(
  parameter int TS_WIDTH  = DEF_TS_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    detector_in,
  input  logic                    enable,
  input  logic                    clear_overflow,
  output logic [CNT_WIDTH-1:0]    event_count,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fifo_level,
  match_event_logger_if.master    bus
);

  logic [TS_WIDTH-1:0]  ts_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 overflow_r;
  logic                 match_s;
  logic                 pop_s;
  logic                 drop_s;
  logic                 full_s;
  logic                 empty_s;

  // Match qualification and drop detection (full with no same-edge pop).
  always_comb begin
    match_s = detector_in & enable;
    pop_s   = bus.event_ready & ~empty_s;
    if (match_s && full_s && !pop_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Timestamp, saturating match counter and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_r       <= {TS_WIDTH{1'b0}};
      count_r    <= {CNT_WIDTH{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (enable) begin
        ts_r <= ts_r + TS_WIDTH'(1);
      end
      if (match_s && (count_r != {CNT_WIDTH{1'b1}})) begin
        count_r <= count_r + CNT_WIDTH'(1);
      end
      // A drop on the same edge as a clear keeps the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clear_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // The pre-increment timestamp is what gets stored for a match.
  event_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clock (clock),
    .reset (reset),
    .push  (match_s),
    .din   (ts_r),
    .pop   (bus.event_ready),
    .dout  (bus.event_timestamp),
    .level (fifo_level),
    .full  (full_s),
    .empty (empty_s)
  );

  assign bus.event_valid = ~empty_s;
  assign event_count     = count_r;
  assign overflow        = overflow_r;

endmodule

// File: tb/tb_match_event_logger.sv
// Directed self-checking bench for match_event_logger (default parameters).
module tb_match_event_logger;
  import match_logger_pkg::*;

  logic        clock;
  logic        reset;
  logic        detector_in;
  logic        enable;
  logic        clear_overflow;
  logic [7:0]  event_count;
  logic        overflow;
  logic [2:0]  fifo_level;

  int passed;
  int total;

  match_event_logger_if #(.TS_WIDTH(16)) bus ();

  match_event_logger dut (
    .clock          (clock),
    .reset          (reset),
    .detector_in    (detector_in),
    .enable         (enable),
    .clear_overflow (clear_overflow),
    .event_count    (event_count),
    .overflow       (overflow),
    .fifo_level     (fifo_level),
    .bus            (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; outputs are stable 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; detector_in = 1'b0; enable = 1'b0;
    clear_overflow = 1'b0; bus.event_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; detector_in = 1'b1; enable = 1'b1; bus.event_ready = 1'b1;
    step();
    idle_inputs();
    total++;
    if ({bus.event_valid, fifo_level, event_count, overflow} !== 13'd0)
      $display("FAIL reset_state: valid=%0b level=%0d count=%0d ovf=%0b, want all 0",
               bus.event_valid, fifo_level, event_count, overflow);
    else passed++;
  endtask

  task automatic test_disable();
    do_reset();
    detector_in = 1'b1; enable = 1'b0; bus.event_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (fifo_level !== 3'd0 || event_count !== 8'd0)
      $display("FAIL disabled_ignore: level=%0d count=%0d, want 0 0", fifo_level, event_count);
    else passed++;
    bus.event_ready = 1'b0; enable = 1'b1;
    step();
    detector_in = 1'b0; enable = 1'b0;
    total++;
    if (bus.event_valid !== 1'b1 || bus.event_timestamp !== 16'd0)
      $display("FAIL held_timestamp: valid=%0b ts=%0d, want 1 0", bus.event_valid, bus.event_timestamp);
    else passed++;
  endtask

  task automatic test_two_matches();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      detector_in = (i == 3 || i == 7);
      step();
      if (i == 3) begin
        total++;
        if (bus.event_valid !== 1'b1 || fifo_level !== 3'd1)
          $display("FAIL push_latency: valid=%0b level=%0d, want 1 1", bus.event_valid, fifo_level);
        else passed++;
      end
    end
    detector_in = 1'b0; enable = 1'b0;
    total++;
    if (fifo_level !== 3'd2 || bus.event_timestamp !== 16'd3 || event_count !== 8'd2)
      $display("FAIL two_matches: level=%0d head=%0d count=%0d, want 2 3 2",
               fifo_level, bus.event_timestamp, event_count);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1; detector_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1 || event_count !== 8'd5 ||
        bus.event_timestamp !== 16'd0)
      $display("FAIL overflow_drop: level=%0d ovf=%0b count=%0d head=%0d, want 4 1 5 0",
               fifo_level, overflow, event_count, bus.event_timestamp);
    else passed++;
    clear_overflow = 1'b1;
    step();
    total++;
    if (overflow !== 1'b1 || event_count !== 8'd6 || fifo_level !== 3'd4)
      $display("FAIL clear_vs_drop: ovf=%0b count=%0d level=%0d, want 1 6 4",
               overflow, event_count, fifo_level);
    else passed++;
    detector_in = 1'b0;
    step();
    clear_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0)
      $display("FAIL clear_overflow: ovf=%0b, want 0", overflow);
    else passed++;
  endtask

  // Continues from test_overflow: full with 0,1,2,3 and timestamp now 7.
  task automatic test_full_push_pop();
    logic [15:0] exp_q [4];
    exp_q[0] = 16'd1; exp_q[1] = 16'd2; exp_q[2] = 16'd3; exp_q[3] = 16'd7;
    enable = 1'b1; detector_in = 1'b1; bus.event_ready = 1'b1;
    step();
    detector_in = 1'b0; enable = 1'b0;
    total++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0 || event_count !== 8'd7)
      $display("FAIL full_push_pop: level=%0d ovf=%0b count=%0d, want 4 0 7",
               fifo_level, overflow, event_count);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.event_valid !== 1'b1 || bus.event_timestamp !== exp_q[i])
        $display("FAIL drain_%0d: valid=%0b head=%0d, want 1 %0d",
                 i, bus.event_valid, bus.event_timestamp, exp_q[i]);
      else passed++;
      step();
    end
    step();
    bus.event_ready = 1'b0;
    total++;
    if (bus.event_valid !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL pop_when_empty: valid=%0b level=%0d, want 0 0", bus.event_valid, fifo_level);
    else passed++;
  endtask

  task automatic test_ts_wrap();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    detector_in = 1'b1;
    step();
    detector_in = 1'b0; enable = 1'b0;
    total++;
    if (fifo_level !== 3'd1 || bus.event_timestamp !== 16'd0)
      $display("FAIL ts_wrap: level=%0d head=%0d, want 1 0", fifo_level, bus.event_timestamp);
    else passed++;
  endtask

  task automatic test_count_saturate();
    do_reset();
    enable = 1'b1; detector_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) begin
        total++;
        if (event_count !== 8'd254)
          $display("FAIL count_254: count=%0d, want 254", event_count);
        else passed++;
      end
    end
    total++;
    if (event_count !== 8'd255 || overflow !== 1'b1 || fifo_level !== 3'd4)
      $display("FAIL count_saturate: count=%0d ovf=%0b level=%0d, want 255 1 4",
               event_count, overflow, fifo_level);
    else passed++;
    reset = 1'b1; bus.event_ready = 1'b1; clear_overflow = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({bus.event_valid, fifo_level, event_count, overflow} !== 13'd0)
      $display("FAIL midstream_reset: valid=%0b level=%0d count=%0d ovf=%0b, want all 0",
               bus.event_valid, fifo_level, event_count, overflow);
    else passed++;
    idle_inputs();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    idle_inputs();
    test_reset();
    test_disable();
    test_two_matches();
    test_overflow();
    test_full_push_pop();
    test_ts_wrap();
    test_count_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 Parameter TS_WIDTH, default 16: width of the timestamp counter and stored event word.
REQ-002 Parameter DEPTH, default 4: number of event FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter CNT_WIDTH, default 8: width of the total-match counter.
REQ-004 Port clock, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port detector_in, input, 1 bit: match pulse from the 1011 sequence detector, one cycle per match.
REQ-007 Port enable, input, 1 bit: when high, the timestamp advances and matches are accepted.
REQ-008 Port event_valid, output, 1 bit: the FIFO head holds an event.
REQ-009 Port event_ready, input, 1 bit: the consumer accepts the head event.
REQ-010 Port event_timestamp, output, TS_WIDTH: timestamp of the head event.
REQ-011 Port event_count, output, CNT_WIDTH: total matches seen while enabled, including dropped matches.
REQ-012 Port overflow, output, 1 bit: sticky flag set when a match is dropped.
REQ-013 Port clear_overflow, input, 1 bit: clears overflow.
REQ-014 Port fifo_level, output, clog2(DEPTH)+1 bits: number of entries currently stored.

Function
REQ-015 The timestamp counter SHALL increment by 1 on each edge with enable=1, hold when enable=0, and wrap from 2^TS_WIDTH-1 to 0.
REQ-016 A match is an edge with detector_in=1 and enable=1; when enable=0, detector_in SHALL be ignored.
REQ-017 A match SHALL push the pre-increment timestamp value into the FIFO; event_valid SHALL be high from the cycle after that edge (latency 1).
REQ-018 The FIFO SHALL be first-word-fall-through: event_valid = (fifo_level != 0), and event_timestamp SHALL equal the head entry.
REQ-019 A pop SHALL occur on an edge with event_valid=1 and event_ready=1; event_ready while empty SHALL have no effect.
REQ-020 A simultaneous push and pop SHALL leave fifo_level unchanged, including when the FIFO is full; no drop occurs in that case.
REQ-021 A push while full without a simultaneous pop SHALL discard the match, leave the FIFO contents unchanged, and set overflow.
REQ-022 event_count SHALL increment on every match, whether stored or dropped, and SHALL saturate at 2^CNT_WIDTH-1.
REQ-023 clear_overflow=1 SHALL clear overflow on the next edge; if a drop occurs on the same edge, set wins and overflow SHALL remain 1.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; fifo_level SHALL range from 0 to DEPTH.
REQ-025 event_timestamp SHALL be don't-care while event_valid=0; the bench SHALL NOT check it then.

Reset
REQ-026 On an edge with reset=1, the following SHALL clear to 0: timestamp, pointers, fifo_level, event_count and overflow; event_valid SHALL read 0 in the following cycle.
REQ-027 reset SHALL take priority over a push, pop or clear_overflow on the same edge; stored events SHALL be lost on reset mid-operation.
REQ-028 FIFO storage contents need not be reset.

Structure
REQ-029 Package match_logger_pkg SHALL hold the default TS_WIDTH, DEPTH and CNT_WIDTH constants and the event word typedef.
REQ-030 The FIFO SHALL be a separate sub-module, event_fifo (synchronous, FWFT, with level output), instantiated once.
REQ-031 The timestamp counter, event counter and overflow logic SHALL live in match_event_logger.

Verification
REQ-032 Reset, then enable=1 with detector_in pulses at timestamps 3 and 7, event_ready=0 -> fifo_level=2, head timestamp=3, event_count=2.
REQ-033 Fill 4 entries, then a 5th match with event_ready=0 -> fifo_level=4, overflow=1, event_count=5, head unchanged; clear_overflow together with a 6th dropped match -> overflow stays 1.
REQ-034 FIFO full, with a match and event_ready=1 on the same edge -> fifo_level stays 4, overflow=0, new tail equals the match timestamp.
REQ-035 Hold enable=1 for 65536 cycles with TS_WIDTH=16 -> timestamp wraps to 0; a match on that cycle stores 0.
REQ-036 Hold detector_in=1 for 300 enabled cycles with CNT_WIDTH=8 -> event_count saturates at 255; a mid-stream reset -> all outputs 0 on the next cycle.
